// File: rtl/fmul_arb_pkg.sv
// Shared constants and sizing helpers for the FMUL32 sharing arbiter.
// Imported by the round-robin picker and the top level.
package fmul_arb_pkg;

    // FMUL32 input-register-to-result latency, in cycles.
    localparam int FMUL_LAT_DEF = 2;

    // Opcode width and the opcode that FMUL32 treats as "no operation".
    localparam int         OPC_W_DEF    = 2;
    localparam logic [1:0] OPC_IDLE_DEF = 2'd3;

    // Width of an in-flight tag: one valid bit plus the requester index.
    function automatic int tag_w(input int num_req);
        return 1 + $clog2(num_req);
    endfunction

endpackage

// File: rtl/fmul_rr_picker.sv
// Round-robin picker: chooses the first eligible requester after the pointer.
// Produces a one-hot grant, its index, and a flag that a grant exists.
module fmul_rr_picker
    import fmul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = tag_w(NUM_REQ) - 1
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    logic [ID_W-1:0] cand;

    // The search starts one past the last winner and wraps, so the last
    // winner has the lowest priority in the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop;
        // without it a path that finds no winner would infer a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!grant_vld_o && eligible_i[cand]) begin
                grant_vld_o   = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one FMUL32 pipeline among NUM_REQ requesters: round-robin issue, tag
// pipe that tracks each op through FMUL32, and one response register per requester.
module fmul_share_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int               NUM_REQ  = 4,
    parameter int               DATA_W   = 32,
    parameter int               OPC_W    = OPC_W_DEF,
    parameter int               FMUL_LAT = FMUL_LAT_DEF,
    parameter logic [OPC_W-1:0] OPC_IDLE = OPC_W'(OPC_IDLE_DEF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    input  logic [NUM_REQ*OPC_W-1:0]  req_opc,
    input  logic [NUM_REQ*2-1:0]      req_rmode,
    input  logic                      hold,
    output logic [DATA_W-1:0]         fmul_op1,
    output logic [DATA_W-1:0]         fmul_op2,
    output logic [OPC_W-1:0]          fmul_opc,
    output logic [1:0]                fmul_rmode,
    input  logic [DATA_W-1:0]         fmul_result,
    input  logic                      fmul_val,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] rsp_result,
    output logic [NUM_REQ-1:0]        rsp_val,
    output logic [NUM_REQ-1:0]        busy,
    output logic                      idle
);

    localparam int ID_W = tag_w(NUM_REQ) - 1;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    // Per-requester views of the packed request buses.
    logic [NUM_REQ-1:0][DATA_W-1:0] op1_s, op2_s;
    logic [NUM_REQ-1:0][OPC_W-1:0]  opc_s;
    logic [NUM_REQ-1:0][1:0]        rmode_s;

    assign op1_s   = req_op1;
    assign op2_s   = req_op2;
    assign opc_s   = req_opc;
    assign rmode_s = req_rmode;

    // State
    logic [ID_W-1:0]                ptr_q, ptr_d;
    logic [DATA_W-1:0]              fmul_op1_q, fmul_op1_d;
    logic [DATA_W-1:0]              fmul_op2_q, fmul_op2_d;
    logic [OPC_W-1:0]               fmul_opc_q, fmul_opc_d;
    logic [1:0]                     fmul_rmode_q, fmul_rmode_d;
    tag_t                           tag_q [FMUL_LAT+1];
    logic [NUM_REQ-1:0]             busy_q, busy_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [NUM_REQ-1:0]             rsp_val_q, rsp_val_d;

    // Grant path
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;

    // Return path
    tag_t               tag_in;
    tag_t               tag_out;
    logic [NUM_REQ-1:0] cap;
    logic [NUM_REQ-1:0] rsp_rd;
    logic [FMUL_LAT:0]  tag_v;

    // A requester owning an op (in flight or unread) is never eligible, which
    // is what guarantees its response register is empty when the result lands.
    assign eligible = req_valid & ~busy_q & {NUM_REQ{~hold & rst_n}};

    fmul_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign req_ready = grant;

    // Issue: load the winner's operands; otherwise idle the opcode and hold the rest.
    always_comb begin
        ptr_d        = ptr_q;
        fmul_op1_d   = fmul_op1_q;
        fmul_op2_d   = fmul_op2_q;
        fmul_opc_d   = OPC_IDLE;
        fmul_rmode_d = fmul_rmode_q;
        if (grant_vld) begin
            ptr_d        = grant_idx;
            fmul_op1_d   = op1_s[grant_idx];
            fmul_op2_d   = op2_s[grant_idx];
            fmul_opc_d   = opc_s[grant_idx];
            fmul_rmode_d = rmode_s[grant_idx];
        end
    end

    assign tag_in  = '{v: grant_vld, id: grant_idx};
    assign tag_out = tag_q[FMUL_LAT];

    always_comb begin
        for (int s = 0; s <= FMUL_LAT; s++) begin
            tag_v[s] = tag_q[s].v;
        end
    end

    // Return: the oldest tag steers the FMUL32 output into its owner's register.
    always_comb begin
        cap          = '0;
        rsp_result_d = rsp_result_q;
        rsp_val_d    = rsp_val_q;
        if (tag_out.v) begin
            cap[tag_out.id]          = 1'b1;
            rsp_result_d[tag_out.id] = fmul_result;
            rsp_val_d[tag_out.id]    = fmul_val;
        end
    end

    assign rsp_rd      = rsp_valid_q & rsp_ready;
    assign rsp_valid_d = (rsp_valid_q & ~rsp_rd) | cap;
    assign busy_d      = (busy_q & ~rsp_rd) | grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            fmul_op1_q   <= '0;
            fmul_op2_q   <= '0;
            fmul_opc_q   <= OPC_IDLE;
            fmul_rmode_q <= '0;
            busy_q       <= '0;
            rsp_valid_q  <= '0;
            // NOTE: the response data registers are reset too, because their
            // contents are visible on rsp_result even while rsp_valid is low.
            rsp_result_q <= '0;
            rsp_val_q    <= '0;
            for (int s = 0; s <= FMUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge value, so the tag shift below moves exactly one stage.
            ptr_q        <= ptr_d;
            fmul_op1_q   <= fmul_op1_d;
            fmul_op2_q   <= fmul_op2_d;
            fmul_opc_q   <= fmul_opc_d;
            fmul_rmode_q <= fmul_rmode_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_val_q    <= rsp_val_d;
            tag_q[0]     <= tag_in;
            for (int s = 1; s <= FMUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign fmul_op1   = fmul_op1_q;
    assign fmul_op2   = fmul_op2_q;
    assign fmul_opc   = fmul_opc_q;
    assign fmul_rmode = fmul_rmode_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_val    = rsp_val_q;
    assign busy       = busy_q;
    assign idle       = ~|tag_v & ~|rsp_valid_q;

    // A result arriving at an occupied response register would be lost.
    a_capture_into_empty : assert property (
        @(posedge clk) disable iff (!rst_n)
        tag_out.v |-> !rsp_valid_q[tag_out.id]
    );

    a_grant_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready)
    );

endmodule
